// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane count
// and the word-alignment helper.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int         LP_BYTE_LANES = 4;
  localparam logic [1:0] LP_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & LP_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word RAM with per-byte write enables: synchronous write, combinational read,
// storage deliberately left without reset.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LP_BYTE_LANES-1:0] be,
  input  logic [AW-1:0]            addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LP_BYTE_LANES; b++) begin
        if (be[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, commits
// and answers with data/error, holding the response until it is taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int                    LP_AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]            LP_CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_WORDS    = ADDR_WIDTH'(MEM_WORDS);

  state_e                     r_state, w_state_nxt;
  logic [3:0]                 r_cnt;
  logic                       r_req_ready, r_busy;
  logic                       r_we;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [31:0]                r_wdata;
  logic [LP_BYTE_LANES-1:0]   r_be;
  logic [31:0]                r_rsp_rdata;
  logic                       r_rsp_err;

  logic                       w_accept, w_enter_resp, w_err, w_mem_we;
  logic                       w_src_we;
  logic [ADDR_WIDTH-1:0]      w_src_addr, w_idx;
  logic [31:0]                w_src_wdata, w_rdata;
  logic [LP_BYTE_LANES-1:0]   w_src_be;

  assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid;

  // With zero latency the commit happens on the acceptance edge itself, so the
  // live request fields are used instead of the (not yet loaded) latch.
  assign w_enter_resp = (w_accept && (LATENCY == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_src_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_src_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_src_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_src_be    = (r_state == S_IDLE) ? req_be    : r_be;

  assign w_idx    = w_src_addr >> 2;
  assign w_err    = is_misaligned(w_src_addr[1:0]) || (w_idx >= LP_WORDS);
  assign w_mem_we = w_enter_resp && w_src_we && !w_err;

  data_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (LP_AW)
  ) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .be    (w_src_be),
    .addr  (w_src_addr[LP_AW+1:2]),
    .wdata (w_src_wdata),
    .rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_accept) r_cnt <= LP_CNT_LOAD;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Response registers only move on RESP entry, so they stay stable while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_err || w_src_we) ? 32'd0 : w_rdata;
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, hand-written corner sequences and
// randomized traffic against a behavioural memory model.
module tb_data_mem_responder;

  localparam int AW = 32;
  localparam int MW = 256;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [AW-1:0] a_req_addr;
  logic [31:0]   a_req_wdata, a_rsp_rdata;
  logic [3:0]    a_req_be;

  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [AW-1:0] b_req_addr;
  logic [31:0]   b_req_wdata, b_rsp_rdata;
  logic [3:0]    b_req_be;

  data_mem_responder #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy));

  data_mem_responder #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [MW];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural memory: plain word array, byte merge, range/alignment rules.
  task automatic model_exec(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rd, output logic err);
    err = (addr % 4 != 0) || (addr / 4 >= MW);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[addr / 4][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = ref_mem[addr / 4];
      end
    end
  endtask

  task automatic txn_a(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input bit hold,
                       output logic [31:0] rd, output logic err);
    int cyc;
    logic [31:0] rd0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
    a_rsp_ready = !hold;
    cyc = 0;
    while (!a_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check({name, "_accept"}, a_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_we = $urandom_range(0, 1); a_req_addr = $urandom; a_req_wdata = $urandom;
    a_req_be = 4'($urandom);
    check({name, "_ready_drop"}, a_req_ready, 0);
    check({name, "_busy"}, a_busy, 1);
    cyc = 0;
    while (!a_rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check({name, "_latency"}, cyc, LAT_A);
    if (hold) begin
      rd0 = a_rsp_rdata;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({name, "_hold_valid"}, a_rsp_valid, 1);
        check({name, "_hold_rdata"}, a_rsp_rdata, rd0);
        check({name, "_hold_ready"}, a_req_ready, 0);
      end
      a_rsp_ready = 1'b1;
    end
    rd  = a_rsp_rdata;
    err = a_rsp_err;
    @(negedge clk);
    check({name, "_done_valid"}, a_rsp_valid, 0);
    check({name, "_done_ready"}, a_req_ready, 1);
    check({name, "_done_busy"}, a_busy, 0);
  endtask

  task automatic run_vec(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_rd, input logic exp_err, input bit hold);
    logic [31:0] rd;
    logic        err;
    txn_a(name, we, addr, wd, be, hold, rd, err);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic run_model(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input bit hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    model_exec(we, addr, wd, be, exp_rd, exp_err);
    run_vec(name, we, addr, wd, be, exp_rd, exp_err, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] mrd;
    logic        merr;
    int          cyc, acc, nrsp;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h0,   32'h01234567, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h11,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h01234567, 1'b0};
    vecs[10] = '{1'b1, 32'h10,  32'h55555555, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h10,  32'h12345678, 4'h6, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE3456AA, 1'b0};

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", a_req_ready, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_rdata", a_rsp_rdata, 0);
    check("rst_rsp_err", a_rsp_err, 0);
    check("rst_busy", a_busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", a_req_ready, 1);

    // zero-latency responder: store then back-to-back loads
    b_req_valid = 1; b_req_we = 1; b_req_addr = 32'h4; b_req_wdata = 32'hA5A5A5A5; b_req_be = 4'hF;
    b_rsp_ready = 1;
    cyc = 0;
    while (!b_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("b_accept", b_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 0;
    check("b_store_rsp_now", b_rsp_valid, 1);
    @(negedge clk);
    check("b_store_done", b_rsp_valid, 0);
    b_req_we = 0; b_req_valid = 1;
    acc = 0; nrsp = 0;
    for (int i = 0; i < 20; i++) begin
      if (b_req_ready) acc++;
      if (b_rsp_valid) begin
        nrsp++;
        check("b_b2b_rdata", b_rsp_rdata, 32'hA5A5A5A5);
        check("b_b2b_err", {31'd0, b_rsp_err}, 0);
      end
      @(negedge clk);
    end
    b_req_valid = 0;
    check("b_b2b_accepts", acc, 10);
    check("b_b2b_responses", nrsp, 10);

    // vector table
    for (int i = 0; i < 13; i++) begin
      model_exec(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be, mrd, merr);
      run_vec($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be,
              vecs[i].exp_rd, vecs[i].exp_err, 1'b0);
    end

    // response held off for five cycles
    run_vec("hold", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE3456AA, 1'b0, 1'b1);

    // reset in the middle of a store's wait states
    run_model("pre_rst_st", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
    run_model("pre_rst_ld", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'hBAD0BAD0; a_req_be = 4'hF;
    a_rsp_ready = 1;
    cyc = 0;
    while (!a_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 0;
    check("midrst_in_wait", a_busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_req_ready", a_req_ready, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_rsp_valid", a_rsp_valid, 0);
    check("midrst_rsp_rdata", a_rsp_rdata, 0);
    check("midrst_rsp_err", a_rsp_err, 0);
    repeat (3) @(negedge clk);
    check("midrst_hold_ready", a_req_ready, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_vec("post_rst_ld", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int w = 0; w < 16; w++) run_model("rnd_init", 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] addr;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind < 8)       addr = 32'($urandom_range(0, 15) * 4);
      else if (kind == 8) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else                addr = 32'((MW + $urandom_range(0, 1000)) * 4);
      run_model("rnd", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom),
                ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the core's data-memory request/response interface: accepts one load or store per transaction from the core's load/store path (the initiator) and answers after a programmable number of wait states. It owns a byte-enabled word memory and flags misaligned or out-of-range accesses. It sits between the core's load/store unit and data storage. It replaces the zero-wait combinational data memory so that the core and its testbench can be exercised against realistic memory latency.

## Interface
- `ADDR_WIDTH`, default 32: request address width.
- `MEM_WORDS`, default 1024: depth of the memory in 32-bit words; must be a power of two.
- `LATENCY`, default 2: wait states between acceptance and response; legal range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  the initiator presents a request.
- `req_ready`  out  1  the responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables for a store; bit i selects byte i.
- `rsp_valid`  out  1  a response is present.
- `rsp_ready`  in  1  the initiator takes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and for errors.
- `rsp_err`  out  1  the access was misaligned or out of range.
- `busy`  out  1  the responder is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - `req_ready`=1.
  - When `req_valid` and `req_ready` are both high at a rising edge, latch `req_we`, `req_addr`, `req_wdata` and `req_be`.
  - Next state is RESP if `LATENCY`=0; otherwise WAIT, with the counter loaded to `LATENCY`-1.
- WAIT
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP.
  - Request inputs are ignored.
- Entering RESP, on a single edge:
  - Error check: `req_addr[1:0]`≠0, or word index `addr>>2` ≥ `MEM_WORDS`, gives `rsp_err`=1, `rsp_rdata`=0 and no memory write.
  - Store without error: write the enabled bytes only, and set `rsp_rdata`=0. `req_be`=0 is a legal no-op with no error.
  - Load without error: register the word at the index into `rsp_rdata`.
- RESP
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_err` stay stable until `rsp_valid` and `rsp_ready` are both high at a rising edge; that handshake moves the FSM to IDLE.
  - `rsp_ready` low holds RESP indefinitely.
- No request is accepted while in WAIT or RESP; only one transaction is outstanding.
- Reset:
  - `rst` low clears the FSM to IDLE immediately.
  - Reset values: `req_ready`=0 while `rst` is low and 1 after release; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
  - Memory contents are not reset; a read of an unwritten word returns X and the bench must write before reading.
- Reset mid-transaction: the transaction is dropped. A store still in WAIT never commits. A store already in RESP has committed and stays committed.

## Timing
- Acceptance at edge k gives RESP entry, the memory write and the `rsp_rdata` update at edge k+`LATENCY`. `rsp_valid` is high from edge k+`LATENCY` onward.
- With `rsp_ready` held at 1:
  - The response handshake happens at edge k+`LATENCY`+1.
  - `req_ready` returns high after that edge.
  - The next acceptance is at the earliest at edge k+`LATENCY`+2, so the sustained rate is one transaction per `LATENCY`+2 cycles.
- A store followed by a load to the same address returns the new data, because the commit happens before the load is accepted.
- `req_ready` is a registered function of state only; it never depends combinationally on `req_valid`.
- `busy` = (state≠IDLE), registered.

## Structure
- The shared package holds:
  - the FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the byte-lane count (4);
  - the word-alignment mask.
- Sub-module `data_mem_array`: a synchronous-write word RAM with byte enables. It has ports `clk`, `we`, `be[3:0]`, `addr`, `wdata` and `rdata`, and no reset on its storage.
- The FSM, wait counter, request latch and error check live in `data_mem_responder`.

## Test plan
- Store `0xDEADBEEF` to `0x10` with `be`=4'hF, then load `0x10` with `LATENCY`=2 → `rsp_rdata`=`0xDEADBEEF`, `rsp_err`=0, and `rsp_valid` rises 2 cycles after acceptance.
- Store `0x000000AA` to `0x10` with `be`=4'b0001 over `0xDEADBEEF` → a load returns `0xDEADBEAA`.
- Load `0x13` (misaligned), and load `4*MEM_WORDS` (out of range) → `rsp_err`=1, `rsp_rdata`=0, and memory is unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` hold and `req_ready` stays 0. Raising `rsp_ready` returns the FSM to IDLE after one edge.
- `LATENCY`=0 with back-to-back loads and `rsp_ready`=1 → one transaction every 2 cycles.
- Assert `rst` low during WAIT of a store to `0x20` → outputs go to their reset values immediately, and a later load of `0x20` does not return the store data.
